// File: rtl/ball_animator.sv
// Per-frame ball position generator for the metaball renderer: steps every ball once per v_sync
// and commits all positions at once. Define BALL_ANIMATOR_PAUSE_EN to add a pause input.
module ball_animator #(
  parameter int unsigned N_BALLS = 3,
  parameter int unsigned H_MAX   = 640,
  parameter int unsigned V_MAX   = 480,
  parameter int unsigned RADIUS  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   v_sync,
`ifdef BALL_ANIMATOR_PAUSE_EN
  input  logic                   pause,
`endif
  output logic [10*N_BALLS-1:0]  ball_x,
  output logic [10*N_BALLS-1:0]  ball_y,
  output logic                   updated,
  output logic [7:0]             frame
);

  localparam int unsigned POS_W = 10;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned SPD_W = 3;
  localparam logic [POS_W-1:0] X_MIN = POS_W'(RADIUS);
  localparam logic [POS_W-1:0] X_MAX = POS_W'(H_MAX - 1 - RADIUS);
  localparam logic [POS_W-1:0] Y_MIN = POS_W'(RADIUS);
  localparam logic [POS_W-1:0] Y_MAX = POS_W'(V_MAX - 1 - RADIUS);

  typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_e;

  function automatic logic [POS_W-1:0] rst_x(input int unsigned i);
    return POS_W'(100 + 160 * i);
  endfunction

  function automatic logic [POS_W-1:0] rst_y(input int unsigned i);
    return POS_W'(120 + 80 * i);
  endfunction

  function automatic logic [SPD_W-1:0] spd_x(input int unsigned i);
    return SPD_W'((i % 4) + 1);
  endfunction

  function automatic logic [SPD_W-1:0] spd_y(input int unsigned i);
    return SPD_W'(((i + 2) % 4) + 1);
  endfunction

  // Returns {flip, new_pos}; out-of-range moves clamp to the edge and reverse direction.
  function automatic logic [POS_W:0] step(input logic [POS_W-1:0] pos, input logic dir,
                                          input logic [SPD_W-1:0] spd,
                                          input logic [POS_W-1:0] lo, input logic [POS_W-1:0] hi);
    logic signed [POS_W:0] nxt;
    nxt = dir ? $signed(11'(pos)) + $signed(11'(spd)) : $signed(11'(pos)) - $signed(11'(spd));
    if (nxt > $signed(11'(hi)))      step = {1'b1, hi};
    else if (nxt < $signed(11'(lo))) step = {1'b1, lo};
    else                             step = {1'b0, nxt[POS_W-1:0]};
  endfunction

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [POS_W-1:0]     wx_q [N_BALLS];
  logic [POS_W-1:0]     wx_d [N_BALLS];
  logic [POS_W-1:0]     wy_q [N_BALLS];
  logic [POS_W-1:0]     wy_d [N_BALLS];
  logic [N_BALLS-1:0]   dx_q, dx_d, dy_q, dy_d;
  logic [10*N_BALLS-1:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic                 updated_q, updated_d;
  logic [7:0]           frame_q, frame_d;
  logic                 vsync_prev_q;
  logic                 trigger_c, start_c;
  logic [POS_W:0]       sx, sy;

  assign trigger_c = ~v_sync & vsync_prev_q;
`ifdef BALL_ANIMATOR_PAUSE_EN
  assign start_c = trigger_c & ~pause;
`else
  assign start_c = trigger_c;
`endif

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wx_d      = wx_q;
    wy_d      = wy_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    updated_d = 1'b0;
    frame_d   = frame_q;
    sx        = '0;
    sy        = '0;
    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          idx_d   = '0;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        for (int unsigned i = 0; i < N_BALLS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sx      = step(wx_q[i], dx_q[i], spd_x(i), X_MIN, X_MAX);
            sy      = step(wy_q[i], dy_q[i], spd_y(i), Y_MIN, Y_MAX);
            wx_d[i] = sx[POS_W-1:0];
            wy_d[i] = sy[POS_W-1:0];
            dx_d[i] = dx_q[i] ^ sx[POS_W];
            dy_d[i] = dy_q[i] ^ sy[POS_W];
          end
        end
        if (idx_q == IDX_W'(N_BALLS - 1)) state_d = COMMIT;
        else                              idx_d   = idx_q + 1'b1;
      end
      COMMIT: begin
        for (int unsigned i = 0; i < N_BALLS; i++) begin
          ball_x_d[10*i +: 10] = wx_q[i];
          ball_y_d[10*i +: 10] = wy_q[i];
        end
        updated_d = 1'b1;
        frame_d   = frame_q + 8'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_BALLS; i++) begin
        wx_q[i]              <= rst_x(i);
        wy_q[i]              <= rst_y(i);
        dx_q[i]              <= (i % 2) == 0;
        dy_q[i]              <= 1'b1;
        ball_x_q[10*i +: 10] <= rst_x(i);
        ball_y_q[10*i +: 10] <= rst_y(i);
      end
      state_q      <= IDLE;
      idx_q        <= '0;
      updated_q    <= 1'b0;
      frame_q      <= 8'd0;
      vsync_prev_q <= 1'b1;
    end else begin
      wx_q         <= wx_d;
      wy_q         <= wy_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      updated_q    <= updated_d;
      frame_q      <= frame_d;
      vsync_prev_q <= v_sync;
    end
  end

  assign ball_x  = ball_x_q;
  assign ball_y  = ball_y_q;
  assign updated = updated_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_ball_animator.sv
// Bench for ball_animator: random frame timing checked against an arithmetic bouncing-ball model.
module tb_ball_animator;
  localparam int NB = 3;
  localparam int H  = 640;
  localparam int V  = 480;
  localparam int R  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            v_sync;
`ifdef BALL_ANIMATOR_PAUSE_EN
  logic            pause;
`endif
  logic [10*NB-1:0] ball_x, ball_y;
  logic            updated;
  logic [7:0]      frame;

  ball_animator #(.N_BALLS(NB), .H_MAX(H), .V_MAX(V), .RADIUS(R)) dut (
    .clk(clk),
    .reset(reset),
    .v_sync(v_sync),
`ifdef BALL_ANIMATOR_PAUSE_EN
    .pause(pause),
`endif
    .ball_x(ball_x),
    .ball_y(ball_y),
    .updated(updated),
    .frame(frame)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int mx [NB];
  int my [NB];
  int mvx[NB];
  int mvy[NB];
  int mframe;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      mx[i]  = 100 + 160 * i;
      my[i]  = 120 + 80 * i;
      mvx[i] = ((i % 4) + 1) * (((i % 2) == 0) ? 1 : -1);
      mvy[i] = ((i + 2) % 4) + 1;
    end
    mframe = 0;
  endfunction

  function automatic void axis(inout int p, inout int v, input int lo, input int hi);
    int n;
    n = p + v;
    if (n > hi)      begin p = hi; v = -v; end
    else if (n < lo) begin p = lo; v = -v; end
    else             p = n;
  endfunction

  function automatic void model_step();
    for (int i = 0; i < NB; i++) begin
      axis(mx[i], mvx[i], R, H - 1 - R);
      axis(my[i], mvy[i], R, V - 1 - R);
    end
    mframe = (mframe + 1) % 256;
  endfunction

  function automatic logic [63:0] pack(input int which);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) r[10*i +: 10] = 10'(which == 0 ? mx[i] : my[i]);
    return r;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, " ball_x"}, 64'(ball_x), pack(0));
    chk({tag, " ball_y"}, 64'(ball_y), pack(1));
    chk({tag, " frame"}, 64'(frame), 64'(mframe));
  endtask

  // Called at a negedge with v_sync high; one trigger, then waits for the commit pulse.
  task automatic run_frame(input string tag, input int lowlen);
    logic [10*NB-1:0] px, py;
    bit stable;
    bit seen;
    int cnt;
    px = ball_x; py = ball_y; stable = 1; seen = 0; cnt = 0;
    v_sync = 1'b0;
    while (!seen && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (cnt >= lowlen) v_sync = 1'b1;
      if (updated === 1'b1) seen = 1;
      else if (ball_x !== px || ball_y !== py || frame !== 8'(mframe)) stable = 0;
    end
    model_step();
    chk({tag, " pulse"}, 64'(seen), 64'd1);
    chk({tag, " latency"}, 64'(cnt), 64'd5);
    chk({tag, " stable"}, 64'(stable), 64'd1);
    check_model(tag);
    @(negedge clk);
    chk({tag, " pulse_len"}, 64'(updated), 64'd0);
    v_sync = 1'b1;
  endtask

  initial begin
    int pulses;
    reset  = 1'b1;
    v_sync = 1'b1;
`ifdef BALL_ANIMATOR_PAUSE_EN
    pause  = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset values
    check_model("reset");
    chk("reset updated", 64'(updated), 64'd0);
    chk("reset x2", 64'(ball_x[29:20]), 64'd420);
    chk("reset y2", 64'(ball_y[29:20]), 64'd280);

    // First frame, explicit positions
    run_frame("frame1", 1);
    chk("f1 x0", 64'(ball_x[9:0]), 64'd101);
    chk("f1 y0", 64'(ball_y[9:0]), 64'd123);
    chk("f1 x1", 64'(ball_x[19:10]), 64'd258);
    chk("f1 y1", 64'(ball_y[19:10]), 64'd204);
    chk("f1 x2", 64'(ball_x[29:20]), 64'd423);
    chk("f1 y2", 64'(ball_y[29:20]), 64'd281);
    chk("f1 frame", 64'(frame), 64'd1);

    // Ball 2 reaches the bottom edge and bounces
    for (int f = 2; f <= 167; f++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame("run", $urandom_range(1, 3));
    end
    chk("f167 y2", 64'(ball_y[29:20]), 64'd447);
    run_frame("f168", 1);
    chk("f168 y2", 64'(ball_y[29:20]), 64'd447);
    run_frame("f169", 2);
    chk("f169 y2", 64'(ball_y[29:20]), 64'd446);

    // Second edge during update is ignored
    pulses = 0;
    v_sync = 1'b0;
    @(negedge clk); v_sync = 1'b1;
    @(negedge clk); v_sync = 1'b0;
    @(negedge clk); v_sync = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (updated === 1'b1) pulses++;
    end
    model_step();
    chk("dbl_edge pulses", 64'(pulses), 64'd1);
    check_model("dbl_edge");

    // v_sync held low for a long time yields one update
    pulses = 0;
    v_sync = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (updated === 1'b1) pulses++;
    end
    v_sync = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (updated === 1'b1) pulses++;
    end
    model_step();
    chk("held_low pulses", 64'(pulses), 64'd1);
    check_model("held_low");

    // Reset in the UPDATE cycle for ball 1
    pulses = 0;
    v_sync = 1'b0;
    @(negedge clk); v_sync = 1'b1;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    repeat (10) begin
      if (updated === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("midreset pulses", 64'(pulses), 64'd0);
    check_model("midreset");

    // 256 frames wrap the frame counter
    for (int f = 0; f < 256; f++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_frame("wrap", $urandom_range(1, 3));
    end
    chk("wrap frame", 64'(frame), 64'd0);

`ifdef BALL_ANIMATOR_PAUSE_EN
    // Paused triggers are consumed without updating
    pause  = 1'b1;
    pulses = 0;
    repeat (10) begin
      v_sync = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      v_sync = 1'b1;
      repeat (8) begin
        @(negedge clk);
        if (updated === 1'b1) pulses++;
      end
    end
    chk("pause pulses", 64'(pulses), 64'd0);
    check_model("pause");
    pause = 1'b0;
    run_frame("unpause", 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ball_animator.md
Name: ball_animator

Overview:
- Generates per-frame positions for the metaball renderer.
- Sits directly upstream of the metaballs pixel stage and is fed by the VGA timing generator's v_sync.
- Once per frame, during vertical sync, it steps every ball by its velocity, bounces balls off the screen edges, and presents all positions atomically.
- The renderer therefore never sees a half-updated set mid-frame.

Parameters:
- N_BALLS, 3, number of balls; legal range 1..4.
- H_MAX, 640, visible width in pixels.
- V_MAX, 480, visible height in pixels.
- RADIUS, 32, edge margin. Legal x range is [RADIUS, H_MAX-1-RADIUS]; legal y range is [RADIUS, V_MAX-1-RADIUS].

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- v_sync  in  1  vertical sync from the VGA timing generator, active low
- ball_x  out  10*N_BALLS  packed x positions; ball i at [10*i+9:10*i]
- ball_y  out  10*N_BALLS  packed y positions, same packing
- updated  out  1  one-cycle pulse when a new position set is committed
- frame  out  8  committed-frame counter

Behaviour:
- Reset table, for ball i:
  - x = 100 + 160*i, y = 120 + 80*i
  - speed vx = (i mod 4) + 1, vy = ((i+2) mod 4) + 1
  - x direction: positive for even i, negative for odd i; y direction: positive for all i
- On reset:
  - working and output registers load the reset table
  - updated=0, frame=0, state=IDLE
  - v_sync history register = 1
- Edge detect: a frame trigger is a cycle where v_sync=0 and the registered previous v_sync=1.
- FSM, three states:
  - IDLE: on trigger, go to UPDATE with idx=0. Otherwise stay.
  - UPDATE: step working ball idx, one ball per cycle. After idx=N_BALLS-1, go to COMMIT.
  - COMMIT: copy all working positions to ball_x/ball_y in one cycle, increment frame, go to IDLE.
- Timing: trigger sampled at cycle t → UPDATE at t+1..t+N_BALLS → COMMIT at t+N_BALLS+1.
  - New ball_x/ball_y, the new frame value, and updated=1 are all visible at cycle t+N_BALLS+2.
  - updated is high for exactly that one cycle.
- Step arithmetic: 11-bit signed, next = pos ± speed.
  - If next > max: pos = max and the direction bit flips.
  - Else if next < min: pos = min and the direction bit flips.
  - Else pos = next.
  - No wrap-around of positions, ever.
- Atomicity: ball_x/ball_y change only in COMMIT and hold otherwise.
- frame wraps from 255 to 0.
- Triggers arriving while not in IDLE are ignored; there is no queueing.
- Reset asserted mid-UPDATE or during COMMIT: the reset table is restored on the next edge, partially stepped values are discarded, and updated=0.
- v_sync held low continuously produces exactly one trigger.

Optional Feature:
- Macro BALL_ANIMATOR_PAUSE_EN.
- When defined:
  - An extra input port "pause" (1 bit) is added.
  - A trigger seen while pause=1 is consumed, but the FSM stays IDLE: no step, no commit, no updated pulse, frame unchanged.
  - pause has no effect once UPDATE has begun; the in-flight frame completes.
- When undefined: no pause port, and every trigger taken in IDLE runs a full update.

Test Plan:
1. Reset sequence:
   - Stimulus: reset high 2 cycles, then low; check before any v_sync edge.
   - Required: ball_x = {420,260,100}, ball_y = {280,200,120}, frame=0, updated=0.
2. Single frame:
   - Stimulus: one v_sync 1→0 edge.
   - Required: exactly 5 cycles after the sampled edge, updated=1 for one cycle.
   - Required positions: ball0 (101,123), ball1 (258,204), ball2 (423,281); frame=1.
   - Required: outputs stable on every cycle before that.
3. Y bounce on ball2:
   - Stimulus: 167 frames.
   - Required: ball2 y=447 after frame 167.
   - Required: frame 168 → y=447 with direction now negative; frame 169 → y=446.
4. Edge during update and held-low v_sync:
   - Stimulus: second falling edge 2 cycles after the first; separately, v_sync held low for 1000 cycles.
   - Required: only one update in each case; frame increments by exactly 1.
5. Reset mid-operation:
   - Stimulus: reset asserted in the UPDATE cycle for idx=1.
   - Required: reset table restored, no updated pulse, frame=0.
6. Frame counter and pause:
   - Stimulus: 256 frames.
   - Required: frame wraps back to 0.
   - With BALL_ANIMATOR_PAUSE_EN and pause=1 over 10 edges: outputs unchanged and no updated pulse.
